// File: rtl/mul_16_seq_pkg.sv
// Shared widths, state encoding and the iteration-counter increment
// for the sequential shift-and-add multiplier.
package mul_pkg;

  localparam int WORD_W = 16;
  localparam int ITER_W = 4;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  // Ripple increment, so the block carries no behavioural adder.
  function automatic logic [ITER_W-1:0] inc_iter(input logic [ITER_W-1:0] v);
    logic [ITER_W-1:0] r;
    logic carry;
    carry = 1'b1;
    for (int i = 0; i < ITER_W; i++) begin
      r[i]  = v[i] ^ carry;
      carry = carry & v[i];
    end
    return r;
  endfunction

endpackage

// File: rtl/mul_16_seq_if.sv
// Operand/product handshake bundle for mul_16_seq.
interface mul_16_seq_if;
  import mul_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] out;
  logic              busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out, busy
  );

endinterface

// File: rtl/mul_16_seq_add_16.sv
// 16-bit ripple-carry adder feeding the multiplier accumulator; carry-out
// is dropped so the sum wraps mod 2^16.
module add_16
  import mul_pkg::*;
(
  input  logic [WORD_W-1:0] x,
  input  logic [WORD_W-1:0] y,
  output logic [WORD_W-1:0] sum
);

  logic carry;

  always_comb begin
    carry = 1'b0;
    sum   = '0;
    for (int i = 0; i < WORD_W; i++) begin
      sum[i] = x[i] ^ y[i] ^ carry;
      carry  = (x[i] & y[i]) | (carry & (x[i] ^ y[i]));
    end
  end

endmodule

// File: rtl/mul_16_seq.sv
// Sequential 16-bit shift-and-add multiplier producing the low 16 bits of
// a*b, with valid/ready on both sides and one operation in flight.
module mul_16_seq
  import mul_pkg::*;
#(
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  mul_16_seq_if.slave  bus
);

  mul_state_t        state_q, state_d;
  logic [WORD_W-1:0] mcand_q, mcand_d;
  logic [WORD_W-1:0] mplier_q, mplier_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] out_q, out_d;
  logic [ITER_W-1:0] cnt_q, cnt_d;
  logic [WORD_W-1:0] sum;
  logic              last_iter;

  add_16 u_add (
    .x   (acc_q),
    .y   (mcand_q),
    .sum (sum)
  );

  // Done after the 16th iteration, or once no multiplier bits remain.
  assign last_iter = (cnt_q == '1) ||
                     (EARLY_EXIT && (mplier_q[WORD_W-1:1] == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = (EARLY_EXIT && (bus.b == '0)) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_iter) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      out_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
    end
  end

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          mcand_d  = bus.a;
          mplier_d = bus.b;
          acc_d    = '0;
          cnt_d    = '0;
        end
      end
      BUSY: begin
        if (mplier_q[0]) begin
          acc_d = sum;
        end
        mcand_d  = {mcand_q[WORD_W-2:0], 1'b0};
        mplier_d = {1'b0, mplier_q[WORD_W-1:1]};
        cnt_d    = inc_iter(cnt_q);
      end
      default: ;
    endcase
    // The product register follows acc while in DONE and then keeps its value.
    out_d = (state_d == DONE) ? acc_d : out_q;
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q == BUSY) || (state_q == DONE);
    bus.out       = out_q;
  end

endmodule

// File: tb/tb_mul_16_seq.sv
// Scoreboard bench for mul_16_seq: one instance per EARLY_EXIT setting,
// directed operands with hand-computed products and latencies.
module tb_mul_16_seq;
  import mul_pkg::*;

  typedef struct {
    logic [15:0] prod;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mul_16_seq_if bus0 ();
  mul_16_seq_if bus1 ();

  mul_16_seq #(.EARLY_EXIT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mul_16_seq #(.EARLY_EXIT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  exp_t        q0[$];
  exp_t        q1[$];
  int          checks = 0;
  int          fails = 0;
  int          cyc = 0;
  int          accept_cyc[2];
  bit          waiting[2];
  logic [15:0] held[2];

  logic [1:0]       iv_s, ir_s, ov_s, or_s, bz_s;
  logic [1:0][15:0] out_s;
  assign iv_s  = {bus1.in_valid, bus0.in_valid};
  assign ir_s  = {bus1.in_ready, bus0.in_ready};
  assign ov_s  = {bus1.out_valid, bus0.out_valid};
  assign or_s  = {bus1.out_ready, bus0.out_ready};
  assign bz_s  = {bus1.busy, bus0.busy};
  assign out_s = {bus1.out, bus0.out};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic pushExp(input int s, input logic [15:0] p, input int l);
    exp_t e;
    e.prod = p;
    e.lat  = l;
    if (s == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic setIn(input int s, input logic v, input logic [15:0] av, input logic [15:0] bv);
    if (s == 0) begin
      bus0.in_valid = v; bus0.a = av; bus0.b = bv;
    end else begin
      bus1.in_valid = v; bus1.a = av; bus1.b = bv;
    end
  endtask

  // Monitor: latency on the first DONE cycle, stability while held, product on handshake.
  task automatic monitorSide(input int s);
    exp_t e;
    if (!rst_n) begin
      waiting[s] = 1'b0;
      return;
    end
    if (iv_s[s] && ir_s[s]) begin
      accept_cyc[s] = cyc;
      waiting[s]    = 1'b1;
      checkOutput($sformatf("busy_idle%0d", s), 32'(bz_s[s]), 32'd0);
    end else if (waiting[s] && !ov_s[s]) begin
      checkOutput($sformatf("busy_run%0d", s), 32'(bz_s[s]), 32'd1);
    end
    if (ov_s[s]) begin
      checkOutput($sformatf("busy_done%0d", s), 32'(bz_s[s]), 32'd1);
      checkOutput($sformatf("in_ready_done%0d", s), 32'(ir_s[s]), 32'd0);
      if (qsize(s) == 0) begin
        checks++;
        fails++;
        $display("[TB] FAIL unexpected_out%0d: got out_valid with out 0x%0h, expected no product", s, out_s[s]);
      end else begin
        e = (s == 0) ? q0[0] : q1[0];
        if (waiting[s]) begin
          checkOutput($sformatf("latency%0d", s), 32'(cyc - accept_cyc[s]), 32'(e.lat));
          waiting[s] = 1'b0;
        end else begin
          checkOutput($sformatf("out_stable%0d", s), 32'(out_s[s]), 32'(held[s]));
        end
        held[s] = out_s[s];
        if (or_s[s]) begin
          if (s == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
          checkOutput($sformatf("product%0d", s), 32'(out_s[s]), 32'(e.prod));
        end
      end
    end
  endtask

  always @(negedge clk) begin
    monitorSide(0);
    monitorSide(1);
  end

  // Present operands until accepted, then scramble them to show they are ignored.
  task automatic applyStimulus(input int s, input logic [15:0] av, input logic [15:0] bv,
                               input logic [15:0] prod, input int lat);
    int n;
    @(posedge clk); #1;
    setIn(s, 1'b1, av, bv);
    pushExp(s, prod, lat);
    n = 0;
    while (!ir_s[s] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir_s[s]) begin
      checks++;
      fails++;
      $display("[TB] FAIL accept_timeout%0d: got in_ready 0 for 50 cycles, expected 1", s);
    end
    @(posedge clk); #1;
    setIn(s, 1'b0, 16'hA5A5, 16'h5A5A);
  endtask

  task automatic waitDrain(input int s);
    int n;
    n = 0;
    while (qsize(s) != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (qsize(s) != 0) begin
      checks++;
      fails++;
      $display("[TB] FAIL drain_timeout%0d: got %0d pending products, expected 0", s, qsize(s));
      if (s == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  task automatic checkIdle(input int s, input string tag);
    checkOutput({tag, "_in_ready"}, 32'(ir_s[s]), 32'd1);
    checkOutput({tag, "_out_valid"}, 32'(ov_s[s]), 32'd0);
    checkOutput({tag, "_out"}, 32'(out_s[s]), 32'd0);
    checkOutput({tag, "_busy"}, 32'(bz_s[s]), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no completion by 100000 time units, expected end of test");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    setIn(0, 1'b0, 16'h0, 16'h0);
    setIn(1, 1'b0, 16'h0, 16'h0);
    bus0.out_ready = 1'b1;
    bus1.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    checkIdle(0, "reset0");
    checkIdle(1, "reset1");
    #1 rst_n = 1'b1;

    applyStimulus(1, 16'h0003, 16'h0005, 16'h000F, 4);  waitDrain(1);
    applyStimulus(0, 16'h00FF, 16'h0101, 16'hFFFF, 17); waitDrain(0);
    applyStimulus(1, 16'hFFFF, 16'hFFFF, 16'h0001, 17); waitDrain(1);
    applyStimulus(0, 16'hFFFF, 16'hFFFF, 16'h0001, 17); waitDrain(0);
    applyStimulus(1, 16'hFFFD, 16'h0007, 16'hFFEB, 4);  waitDrain(1);
    applyStimulus(1, 16'h1234, 16'h0000, 16'h0000, 1);  waitDrain(1);
    applyStimulus(0, 16'h1234, 16'h0000, 16'h0000, 17); waitDrain(0);
    applyStimulus(1, 16'h0003, 16'h0100, 16'h0300, 10); waitDrain(1);
    applyStimulus(0, 16'h1234, 16'h0005, 16'h5B04, 17); waitDrain(0);

    // Backpressure: hold the product while new operands wait on in_valid.
    bus1.out_ready = 1'b0;
    applyStimulus(1, 16'h0003, 16'h0005, 16'h000F, 4);
    n = 0;
    while (!ov_s[1] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("bp_reach_done", 32'(ov_s[1]), 32'd1);
    fork
      applyStimulus(1, 16'h0007, 16'h0003, 16'h0015, 3);
      begin
        repeat (5) @(posedge clk);
        #1 bus1.out_ready = 1'b1;
      end
    join
    waitDrain(1);

    // Abandon an operation with an asynchronous reset pulse mid-iteration.
    @(posedge clk); #1;
    setIn(0, 1'b1, 16'h1234, 16'h00FF);
    @(posedge clk); #1;
    setIn(0, 1'b0, 16'h0, 16'h0);
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checkIdle(0, "midreset0");
    #1 rst_n = 1'b1;

    applyStimulus(0, 16'h0002, 16'h0002, 16'h0004, 17); waitDrain(0);
    applyStimulus(1, 16'h0002, 16'h0002, 16'h0004, 3);  waitDrain(1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
